// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one EX-stage ALU between the issue port (0) and the debug port (1).
// Requests are registered before driving the ALU; results are held until the consumer takes them.
module alu_share_arbiter #(
    parameter int DATA_W = 8,
    parameter int OP_W = 5,
    parameter logic [OP_W-1:0] OP_MAX = 5'h11,
    parameter logic [OP_W-1:0] OP_IDLE = 5'h1F
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [OP_W-1:0]   req0_opcode,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [OP_W-1:0]   req1_opcode,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic [OP_W-1:0]   alu_opcode,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_carry,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_carry,
    output logic              rsp_err,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t            state;
    logic              last_gnt;
    logic              can_accept;
    logic              accept;
    logic              gnt_id;
    logic [OP_W-1:0]   sel_op;
    logic [DATA_W-1:0] sel_a;
    logic [DATA_W-1:0] sel_b;

    // A new request can be taken in IDLE, or in RESP once the current response is consumed.
    // Ready is forced low while reset is asserted so nothing is seen as accepted.
    always_comb begin
        can_accept = rst_n && ((state == IDLE) || ((state == RESP) && rsp_ready));
        gnt_id     = (req0_valid && req1_valid) ? ~last_gnt : req1_valid;
        accept     = can_accept && (req0_valid || req1_valid);
        req0_ready = accept && !gnt_id;
        req1_ready = accept && gnt_id;
        sel_op     = gnt_id ? req1_opcode : req0_opcode;
        sel_a      = gnt_id ? req1_a : req0_a;
        sel_b      = gnt_id ? req1_b : req0_b;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_gnt   <= 1'b1;
            alu_opcode <= OP_IDLE;
            alu_a      <= '0;
            alu_b      <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_data   <= '0;
            rsp_carry  <= 1'b0;
            rsp_err    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        alu_opcode <= sel_op;
                        alu_a      <= sel_a;
                        alu_b      <= sel_b;
                        rsp_id     <= gnt_id;
                        last_gnt   <= gnt_id;
                        busy       <= 1'b1;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    alu_opcode <= OP_IDLE;
                    rsp_valid  <= 1'b1;
                    state      <= RESP;
                    if (alu_opcode > OP_MAX) begin
                        rsp_data  <= '0;
                        rsp_carry <= 1'b0;
                        rsp_err   <= 1'b1;
                    end else begin
                        rsp_data  <= alu_result;
                        rsp_carry <= alu_carry;
                        rsp_err   <= 1'b0;
                    end
                end
                RESP: begin
                    // The old response retires here even when a new request is accepted
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        if (accept) begin
                            alu_opcode <= sel_op;
                            alu_a      <= sel_a;
                            alu_b      <= sel_b;
                            rsp_id     <= gnt_id;
                            last_gnt   <= gnt_id;
                            state      <= EXEC;
                        end else begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    alu_opcode <= OP_IDLE;
                    rsp_valid  <= 1'b0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: directed scenarios plus a randomized run
// compared against a transaction-level model of the arbiter and an environment ALU.
module tb_alu_share_arbiter;

    logic       clk;
    logic       rst_n;
    logic       req0_valid, req1_valid;
    logic       req0_ready, req1_ready;
    logic [4:0] req0_opcode, req1_opcode;
    logic [7:0] req0_a, req0_b, req1_a, req1_b;
    logic [4:0] alu_opcode;
    logic [7:0] alu_a, alu_b, alu_result;
    logic       alu_carry;
    logic       rsp_valid, rsp_ready, rsp_id, rsp_carry, rsp_err, busy;
    logic [7:0] rsp_data;

    int checks = 0;
    int errors = 0;

    // Model state: one op in flight and one response slot
    logic       m_last, m_inflight, m_if_id, m_rsp_valid, m_rsp_id;
    logic [4:0] m_op;
    logic [7:0] m_a, m_b;
    logic [9:0] m_rsp_word;

    alu_share_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
        .req1_a(req1_a), .req1_b(req1_b),
        .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_carry(alu_carry),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_carry(rsp_carry), .rsp_err(rsp_err), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Environment ALU: 09 add, 0A sub (borrow), other legal ops a simple mix; illegal ops emit garbage carry
    function automatic logic [8:0] alu_fn(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b);
        if (op == 5'h09) return {1'b0, a} + {1'b0, b};
        if (op == 5'h0A) return {(a < b), a - b};
        if (op > 5'h11) return {1'b1, a ^ b};
        return {1'b0, (a ^ b) + {3'b000, op}};
    endfunction

    assign {alu_carry, alu_result} = alu_fn(alu_opcode, alu_a, alu_b);

    function automatic logic [9:0] exp_resp(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b);
        if (op > 5'h11) return {1'b1, 1'b0, 8'h00};
        return {1'b0, alu_fn(op, a, b)};
    endfunction

    // {accept, granted port} the model expects for the inputs currently applied
    function automatic logic [1:0] model_grant();
        logic acc, id;
        acc = !m_inflight && (!m_rsp_valid || rsp_ready) && (req0_valid || req1_valid);
        id  = (req0_valid && req1_valid) ? ~m_last : req1_valid;
        return {acc, id};
    endfunction

    task automatic model_reset();
        m_last = 1'b1; m_inflight = 1'b0; m_if_id = 1'b0; m_rsp_valid = 1'b0;
        m_rsp_id = 1'b0; m_op = 5'h1F; m_a = 8'h00; m_b = 8'h00; m_rsp_word = 10'h000;
    endtask

    task automatic set_req(input logic v0, input logic [4:0] o0, input logic [7:0] a0, input logic [7:0] b0,
                           input logic v1, input logic [4:0] o1, input logic [7:0] a1, input logic [7:0] b1,
                           input logic rr);
        req0_valid = v0; req0_opcode = o0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_opcode = o1; req1_a = a1; req1_b = b1;
        rsp_ready = rr;
    endtask

    // Advance one clock and move the model forward with the inputs that were sampled
    task automatic tick();
        logic [1:0] g;
        g = model_grant();
        @(posedge clk);
        if (m_inflight) begin
            m_rsp_valid = 1'b1;
            m_rsp_id    = m_if_id;
            m_rsp_word  = exp_resp(m_op, m_a, m_b);
            m_inflight  = 1'b0;
        end else if (m_rsp_valid && rsp_ready) begin
            m_rsp_valid = 1'b0;
        end
        if (g[1]) begin
            m_inflight = 1'b1;
            m_if_id    = g[0];
            m_last     = g[0];
            m_op       = g[0] ? req1_opcode : req0_opcode;
            m_a        = g[0] ? req1_a : req0_a;
            m_b        = g[0] ? req1_b : req0_b;
        end
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            set_req(1'b0, 5'h00, 8'h00, 8'h00, 1'b0, 5'h00, 8'h00, 8'h00, 1'b1);
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            set_req(1'($urandom), 5'($urandom), 8'($urandom), 8'($urandom),
                    1'($urandom), 5'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
            req0_valid = 1'b1;
            #1;
            checks++;
            if ({req0_ready, req1_ready, rsp_valid, rsp_id, rsp_carry, rsp_err, busy} !== 7'b0) begin
                errors++;
                $display("[TB] FAIL reset_flags: got r0=%b r1=%b v=%b id=%b c=%b e=%b busy=%b want all 0",
                         req0_ready, req1_ready, rsp_valid, rsp_id, rsp_carry, rsp_err, busy);
            end
            checks++;
            if (alu_opcode !== 5'h1F || alu_a !== 8'h00 || alu_b !== 8'h00 || rsp_data !== 8'h00) begin
                errors++;
                $display("[TB] FAIL reset_data: got op=%h a=%h b=%h data=%h want op=1f a=00 b=00 data=00",
                         alu_opcode, alu_a, alu_b, rsp_data);
            end
        end
        @(negedge clk);
        set_req(1'b0, 5'h00, 8'h00, 8'h00, 1'b0, 5'h00, 8'h00, 8'h00, 1'b1);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_single_add();
        @(negedge clk);
        set_req(1'b1, 5'h09, 8'hF0, 8'h20, 1'b0, 5'h00, 8'h00, 8'h00, 1'b1);
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL add_ready: got r0=%b r1=%b want r0=1 r1=0", req0_ready, req1_ready);
        end
        tick();
        checks++;
        if (alu_opcode !== 5'h09 || alu_a !== 8'hF0 || alu_b !== 8'h20 || rsp_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL add_exec: got op=%h a=%h b=%h v=%b busy=%b want op=09 a=f0 b=20 v=0 busy=1",
                     alu_opcode, alu_a, alu_b, rsp_valid, busy);
        end
        @(negedge clk);
        req0_valid = 1'b0;
        tick();
        checks++;
        if ({rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_err} !== {1'b1, 1'b0, 8'h10, 1'b1, 1'b0}) begin
            errors++;
            $display("[TB] FAIL add_resp: got v=%b id=%b data=%h c=%b e=%b want v=1 id=0 data=10 c=1 e=0",
                     rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_err);
        end
        checks++;
        if (alu_opcode !== 5'h1F) begin
            errors++;
            $display("[TB] FAIL add_opidle: got %h want 1f", alu_opcode);
        end
        idle_cycles(2);
    endtask

    task automatic test_contention();
        logic       exp_id;
        logic [7:0] ga, gb;
        exp_id = ~m_last;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            set_req(1'b1, 5'h06, 8'($urandom), 8'($urandom), 1'b1, 5'h06, 8'($urandom), 8'($urandom), 1'b1);
            ga = exp_id ? req1_a : req0_a;
            gb = exp_id ? req1_b : req0_b;
            #1;
            checks++;
            if (req0_ready !== !exp_id || req1_ready !== exp_id) begin
                errors++;
                $display("[TB] FAIL cont_grant%0d: got r0=%b r1=%b want port %0d", i, req0_ready, req1_ready, exp_id);
            end
            tick();
            @(negedge clk);
            set_req(1'b1, 5'h06, 8'($urandom), 8'($urandom), 1'b1, 5'h06, 8'($urandom), 8'($urandom), 1'b1);
            #1;
            checks++;
            if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL cont_exec_ready%0d: got r0=%b r1=%b want 0 0", i, req0_ready, req1_ready);
            end
            tick();
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== exp_id || rsp_data !== 8'((ga ^ gb) + 8'h06)) begin
                errors++;
                $display("[TB] FAIL cont_resp%0d: got v=%b id=%b data=%h want v=1 id=%b data=%h",
                         i, rsp_valid, rsp_id, rsp_data, exp_id, 8'((ga ^ gb) + 8'h06));
            end
            exp_id = ~exp_id;
        end
        idle_cycles(2);
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        set_req(1'b0, 5'h00, 8'h00, 8'h00, 1'b1, 5'h0A, 8'h05, 8'h07, 1'b0);
        tick();
        @(negedge clk);
        set_req(1'b1, 5'($urandom), 8'($urandom), 8'($urandom), 1'b1, 5'($urandom), 8'($urandom), 8'($urandom), 1'b0);
        tick();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            set_req(1'b1, 5'($urandom), 8'($urandom), 8'($urandom), 1'b1, 5'($urandom), 8'($urandom), 8'($urandom), 1'b0);
            #1;
            checks++;
            if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL bp_ready%0d: got r0=%b r1=%b want 0 0", i, req0_ready, req1_ready);
            end
            checks++;
            if ({rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_err} !== {1'b1, 1'b1, 8'hFE, 1'b1, 1'b0}) begin
                errors++;
                $display("[TB] FAIL bp_hold%0d: got v=%b id=%b data=%h c=%b e=%b want v=1 id=1 data=fe c=1 e=0",
                         i, rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_err);
            end
            tick();
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_release_grant: got r0=%b r1=%b want r0=1 r1=0", req0_ready, req1_ready);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_exec_drop: got v=%b busy=%b want v=0 busy=1", rsp_valid, busy);
        end
        idle_cycles(3);
    endtask

    task automatic test_illegal();
        @(negedge clk);
        set_req(1'b0, 5'h00, 8'h00, 8'h00, 1'b1, 5'h15, 8'h33, 8'h44, 1'b1);
        #1;
        checks++;
        if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ill_ready: got r0=%b r1=%b want r0=0 r1=1", req0_ready, req1_ready);
        end
        tick();
        @(negedge clk);
        req1_valid = 1'b0;
        tick();
        checks++;
        if ({rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_err} !== {1'b1, 1'b1, 8'h00, 1'b0, 1'b1}) begin
            errors++;
            $display("[TB] FAIL ill_resp: got v=%b id=%b data=%h c=%b e=%b want v=1 id=1 data=00 c=0 e=1",
                     rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_err);
        end
        idle_cycles(2);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        set_req(1'b1, 5'h09, 8'h12, 8'h34, 1'b0, 5'h00, 8'h00, 8'h00, 1'b1);
        tick();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || alu_opcode !== 5'h1F || alu_a !== 8'h00 || req0_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midrst_clear: got v=%b busy=%b op=%h a=%h r0=%b want 0 0 1f 00 0",
                     rsp_valid, busy, alu_opcode, alu_a, req0_ready);
        end
        model_reset();
        @(negedge clk);
        set_req(1'b0, 5'h00, 8'h00, 8'h00, 1'b0, 5'h00, 8'h00, 8'h00, 1'b1);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL midrst_quiet%0d: got v=%b busy=%b want 0 0", i, rsp_valid, busy);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        logic [1:0] g;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            set_req(($urandom_range(0, 9) < 6), 5'($urandom_range(0, 23)), 8'($urandom), 8'($urandom),
                    ($urandom_range(0, 9) < 6), 5'($urandom_range(0, 23)), 8'($urandom), 8'($urandom),
                    ($urandom_range(0, 9) < 7));
            #1;
            g = model_grant();
            checks++;
            if (req0_ready !== (g[1] && !g[0]) || req1_ready !== (g[1] && g[0])) begin
                errors++;
                $display("[TB] FAIL rnd_ready%0d: got r0=%b r1=%b want r0=%b r1=%b",
                         i, req0_ready, req1_ready, g[1] && !g[0], g[1] && g[0]);
            end
            tick();
            checks++;
            if (rsp_valid !== m_rsp_valid || busy !== (m_inflight || m_rsp_valid) ||
                alu_opcode !== (m_inflight ? m_op : 5'h1F)) begin
                errors++;
                $display("[TB] FAIL rnd_state%0d: got v=%b busy=%b op=%h want v=%b busy=%b op=%h", i,
                         rsp_valid, busy, alu_opcode, m_rsp_valid, m_inflight || m_rsp_valid,
                         m_inflight ? m_op : 5'h1F);
            end
            if (m_rsp_valid) begin
                checks++;
                if ({rsp_err, rsp_carry, rsp_data} !== m_rsp_word || rsp_id !== m_rsp_id) begin
                    errors++;
                    $display("[TB] FAIL rnd_resp%0d: got id=%b e=%b c=%b data=%h want id=%b e=%b c=%b data=%h", i,
                             rsp_id, rsp_err, rsp_carry, rsp_data, m_rsp_id, m_rsp_word[9], m_rsp_word[8],
                             m_rsp_word[7:0]);
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        set_req(1'b0, 5'h00, 8'h00, 8'h00, 1'b0, 5'h00, 8'h00, 8'h00, 1'b0);
        model_reset();
        test_reset();
        test_single_add();
        test_contention();
        test_backpressure();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
